hilo_mdu: RTL
=============

// Module: hilo_mdu
// PURPOSE
//  Execute-stage multiply/divide unit that owns the HI/LO register pair.
//  Consumes MULT/MULTU/DIV/DIVU issue and hilo_we (MTHI/MTLO) from the
//  controller; returns a stall request to the hazard unit while dividing.
//  MULT: 1-cycle commit. DIV: iterative radix-2 restoring, 34 cycles.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; divider iterates WIDTH times
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-low reset
//  start      in   1      E-stage mult/div instruction valid (held while stalled)
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a          in   WIDTH  rs operand (dividend / multiplicand)
//  b          in   WIDTH  rt operand (divisor / multiplier)
//  cancel     in   1      flushE: abort in-flight op, no HI/LO update
//  hilo_we    in   2      [1] write HI, [0] write LO (MTHI/MTLO, W stage)
//  hilo_wdata in   WIDTH  data for hilo_we writes
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
//  stall_req  out  1      hold F/D/E stages; combinational
//  div_done   out  1      1-cycle pulse in the divide commit cycle
// BEHAVIOUR
//  - Reset (rst==0 at edge): hi=0, lo=0, state=IDLE, counter=0; stall_req=0,
//    div_done=0. Reset mid-divide discards the operation.
//  - FSM IDLE -> RUN -> FIX -> IDLE.
//    IDLE: start&~cancel&op[1]: latch |a|,|b| (abs only for DIV), sign flags,
//      counter=0 -> RUN. start&~cancel&~op[1]: commit {hi,lo} = a*b
//      (signed 64-bit for MULT, unsigned for MULTU) at this edge; stay IDLE.
//    RUN: one restoring step per cycle (shift rem:quo left, trial subtract,
//      set quo bit if non-negative); after WIDTH steps -> FIX.
//    FIX: apply signs (quotient negated if signs differ for DIV, remainder
//      takes dividend sign); lo=quotient, hi=remainder at end of FIX; -> IDLE.
//  - start is ignored in RUN and FIX (instruction is held in E by stall).
//  - stall_req = (IDLE & start & op[1] & ~cancel) | RUN. Low in FIX so the
//    pipeline advances on the same edge as the commit. Divide: start seen in
//    cycle T, stall_req high T..T+32, FIX = T+33, HI/LO valid from T+34.
//  - div_done = (state==FIX) & ~cancel.
//  - Divide by zero: no trap; lo = all ones, hi = a (raw dividend), same timing.
//  - Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0.
//  - cancel: any state -> IDLE next edge, HI/LO not updated by the op,
//    stall_req forced 0 that cycle. hilo_we writes still apply.
//  - hilo_we: write HI/LO independently at edge. Same edge as mult/div commit:
//    commit wins for both halves (commit is the younger instruction).
//  - Arithmetic: |x| of WIDTH-bit signed uses WIDTH-bit unsigned result
//    (0x80000000 stays 0x80000000 unsigned); remainder reg WIDTH+1 bits.
// STRUCTURE
//  - defines.vh: op encodings MDU_MULT/MULTU/DIV/DIVU, FSM state codes.
//  - One sub-module: div_radix2 (RUN/FIX datapath + counter, start/cancel in,
//    quotient/remainder/valid out); hilo_mdu holds FSM glue, multiplier,
//    HI/LO regs and write-priority mux.
// TESTING
//  1 rst=0 2 cycles with start=1 -> hi=lo=0, stall_req=0; release, idle ok.
//  2 MULT a=0xFFFFFFFE(-2) b=3 -> next cycle hi=0xFFFFFFFF lo=0xFFFFFFFA;
//    MULTU same operands -> hi=0x00000002 lo=0xFFFFFFFA; no stall.
//  3 DIV a=-7 b=2 -> stall_req high exactly 33 cycles, div_done at T+33,
//    lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIVU 100/7 -> lo=14 hi=2.
//  4 DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  5 cancel at T+10 of DIV with hi=lo=0x1234 -> IDLE next cycle, stall_req 0,
//    hi/lo stay 0x1234; new DIV issued next cycle completes normally.
//  6 hilo_we=2'b11 wdata=0xAA in FIX cycle of DIVU 9/4 -> lo=2 hi=1 (commit
//    wins); hilo_we=2'b10 wdata=0xAA in IDLE -> hi=0xAA, lo unchanged.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// rtl/hilo_mdu_pkg.sv - op encodings and divider FSM states for the HI/LO multiply/divide unit
package hilo_mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// rtl/hilo_mdu_div_radix2.sv - iterative radix-2 restoring divider with sign fix-up
module hilo_mdu_div_radix2
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output div_state_e       state_o,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, trial;
  logic             div_zero;

  // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps onto itself.
  assign a_abs   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          dvd_d   = a;
          q_neg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_d = is_signed && a[WIDTH-1];
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (cancel) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // Divide by zero does not trap: all-ones quotient, raw dividend as remainder.
  assign div_zero  = (dvs_q == '0);
  assign quotient  = div_zero ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign remainder = div_zero ? dvd_q : (r_neg_q ? -rem_q : rem_q);
  assign valid     = (state_q == ST_FIX) && !cancel;
  assign state_o   = state_q;

endmodule

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - execute-stage multiply/divide unit owning the HI/LO register pair
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_req,
  output logic             div_done
);

  div_state_e         div_state;
  logic               div_valid;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               div_issue, mul_commit, is_idle;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  assign is_idle    = (div_state == ST_IDLE);
  assign div_issue  = is_idle && start && op[1] && !cancel;
  assign mul_commit = is_idle && start && !op[1] && !cancel;

  hilo_mdu_div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start && op[1]),
    .cancel    (cancel),
    .is_signed (!op[0]),
    .a         (a),
    .b         (b),
    .state_o   (div_state),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Extending to 2*WIDTH and keeping the low half gives the exact signed or unsigned product.
  assign a_ext   = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext   = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;

  // A commit is the younger instruction, so it overrides an MTHI/MTLO on the same edge.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we[1]) hi_d = hilo_wdata;
    if (hilo_we[0]) lo_d = hilo_wdata;
    if (mul_commit) {hi_d, lo_d} = product;
    if (div_valid) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = rst && (div_issue || ((div_state == ST_RUN) && !cancel));
  assign div_done  = rst && div_valid;

endmodule
